// File: rtl/isqrt_sched_pkg.sv
// Shared constants, types and the bit-pair square-root step used by the
// isqrt pipeline and the round-robin scheduler around it.
package isqrt_sched_pkg;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_N_STAGES = 16;
  localparam int unsigned DEF_MAX_OUT  = 4;
  localparam int unsigned MAX_N_REQ    = 8;
  localparam int unsigned TAG_W        = $clog2(MAX_N_REQ);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [3:0]       cnt_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] x;
    logic [19:0] rem;
    logic [15:0] root;
  } sq_stage_t;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One restoring iteration: consume the top two operand bits, decide one root bit.
  function automatic sq_stage_t sqrt_step(input sq_stage_t s);
    sq_stage_t   o;
    logic [19:0] trial;
    o     = s;
    o.rem = {s.rem[17:0], s.x[31:30]};
    o.x   = {s.x[29:0], 2'b00};
    trial = {2'b00, s.root, 2'b01};
    if (o.rem >= trial) begin
      o.rem  = o.rem - trial;
      o.root = {s.root[14:0], 1'b1};
    end else begin
      o.root = {s.root[14:0], 1'b0};
    end
    return o;
  endfunction

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based circular FIFO tracking occupancy with an explicit counter.
module flip_flop_fifo_with_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 17
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  always_comb begin
    o_full  = (r_cnt == CW'(DEPTH));
    o_empty = (r_cnt == '0);
    w_push  = i_push && !o_full;
    w_pop   = i_pop && !o_empty;
    o_data  = r_mem[r_rd];
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/isqrt.sv
// Pipelined 32-bit integer square root; latency is n_pipe_stages cycles,
// the 16 root iterations being spread evenly across the stages.
module isqrt
  import isqrt_sched_pkg::*;
#(
  parameter int unsigned n_pipe_stages = DEF_N_STAGES
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_x_vld,
  input  logic [31:0] i_x,
  output logic        o_y_vld,
  output logic [15:0] o_y
);

  sq_stage_t r_st  [n_pipe_stages];
  sq_stage_t w_in  [n_pipe_stages];
  sq_stage_t w_nxt [n_pipe_stages];

  always_comb begin
    w_in[0] = '{vld: i_x_vld, x: i_x, rem: '0, root: '0};
    for (int unsigned s = 1; s < n_pipe_stages; s++) begin
      w_in[s] = r_st[s-1];
    end
    for (int unsigned s = 0; s < n_pipe_stages; s++) begin
      w_nxt[s] = w_in[s];
      for (int unsigned k = 0; k < 16; k++) begin
        if (k >= (s * 16) / n_pipe_stages && k < ((s + 1) * 16) / n_pipe_stages) begin
          w_nxt[s] = sqrt_step(w_nxt[s]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < n_pipe_stages; s++) begin
      if (i_rst) r_st[s] <= '0;
      else       r_st[s] <= w_nxt[s];
    end
  end

  assign o_y_vld = r_st[n_pipe_stages-1].vld;
  assign o_y     = r_st[n_pipe_stages-1].root;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic          w_any;
  int unsigned   w_j;

  always_comb begin
    o_gnt     = '0;
    w_any     = 1'b0;
    w_ptr_nxt = r_ptr;
    w_j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = (32'(r_ptr) + k) % N;
      if (!w_any && i_req[w_j]) begin
        w_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        w_ptr_nxt  = PW'((w_j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n)   r_ptr <= '0;
    else if (w_any) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/isqrt_rr_sched.sv
// Shares one pipelined isqrt among N_REQ requesters; a tag FIFO, pushed on
// issue and popped on y_vld, routes each in-order result back to its owner.
module isqrt_rr_sched
  import isqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned N_STAGES = DEF_N_STAGES,
  parameter int unsigned MAX_OUT  = DEF_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_vld,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]  req_rdy,
  output logic [N_REQ-1:0]  rsp_vld,
  output logic [15:0]       rsp_y,
  output logic              busy
);

  localparam int unsigned TW = tag_width(N_REQ);

  logic [N_REQ-1:0] w_elig, w_gnt, w_rsp_vld;
  logic [TW-1:0]    w_gidx, w_pop_tag;
  tag_t             w_tag;
  logic             r_x_vld;
  logic [31:0]      r_x;
  logic             w_y_vld, w_full, w_empty;
  logic [15:0]      w_y;
  cnt_t             r_cnt [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_elig[i] = rst_n && req_vld[i] && (r_cnt[i] < cnt_t'(MAX_OUT)) && !w_full;
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gidx = TW'(i);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_req   (w_elig),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_vld <= 1'b0;
      r_x     <= '0;
    end else begin
      r_x_vld <= |w_gnt;
      if (|w_gnt) r_x <= req_x[32*w_gidx +: 32];
    end
  end

  isqrt #(.n_pipe_stages(N_STAGES)) u_isqrt (
    .clk     (clk),
    .i_rst   (~rst_n),
    .i_x_vld (r_x_vld),
    .i_x     (r_x),
    .o_y_vld (w_y_vld),
    .o_y     (w_y)
  );

  flip_flop_fifo_with_counter #(.WIDTH(TW), .DEPTH(N_STAGES + 1)) u_tags (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_push  (|w_gnt),
    .i_data  (w_gidx),
    .i_pop   (w_y_vld),
    .o_data  (w_pop_tag),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tag     = tag_t'(w_pop_tag);
  assign w_rsp_vld = (rst_n && w_y_vld) ? (N_REQ'(1) << w_tag) : '0;
  assign req_rdy   = w_gnt;
  assign rsp_vld   = w_rsp_vld;
  assign rsp_y     = (rst_n && w_y_vld) ? w_y : '0;
  assign busy      = rst_n && (!w_empty || r_x_vld);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        case ({w_gnt[i], w_rsp_vld[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + cnt_t'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - cnt_t'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_y_vld && w_empty)) else $fatal(1, "tag FIFO popped while empty");
      for (int unsigned i = 0; i < N_REQ; i++) begin
        assert (r_cnt[i] <= cnt_t'(MAX_OUT));
      end
    end
  end

endmodule
